// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder. Operands stream through one 4-bit
//   carry-lookahead slice (lookahead_adder_4bits), one nibble per clock,
//   least-significant nibble first. The result is published on the
//   RUN->DONE transition.
//
// Optional feature: define NSA_OVERFLOW_EN to add the signed-overflow
//   output (ovf) and the operand-MSB capture registers behind it.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      request; a, b, cin sampled with it in IDLE or DONE
//   a, b       WIDTH-bit operands
//   cin        carry-in
//   busy       high while nibbles are being processed (state RUN)
//   done       one-cycle result-valid pulse (state DONE)
//   sum        registered result, held until the next RUN->DONE
//   cout       registered carry-out of the MSB nibble
//   ovf        signed overflow (NSA_OVERFLOW_EN only)
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: start is a request without ready; it is accepted on any
//   rising edge where the FSM is in IDLE or DONE and ignored while busy.
//   done is high for exactly one cycle per accepted request; busy and
//   done are never high together.

module lookahead_adder_4bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat two-level function of g, p and cin.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       dbg_state
`ifdef NSA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] res_sh;

    logic [3:0]       nib_sum;
    logic             nib_cout;
    logic             last;
    logic [WIDTH+3:0] shift_cat;
    logic [WIDTH-1:0] res_next;

`ifdef NSA_OVERFLOW_EN
    logic a_msb;
    logic b_msb;
`endif

    lookahead_adder_4bits u_cla (
        .a    (a_reg[3:0]),
        .b    (b_reg[3:0]),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    assign last = (cnt == LAST);

    // New nibble enters at the top; after NIB shifts nibble 0 sits at the
    // bottom. Built through a wider concatenation so WIDTH=4 needs no
    // empty slice.
    assign shift_cat = {nib_sum, res_sh};
    assign res_next  = shift_cat[WIDTH+3:4];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = last ? DONE : RUN;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign dbg_state = state;

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            res_sh <= '0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef NSA_OVERFLOW_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else if (state == RUN) begin
            a_reg  <= a_reg >> 4;
            b_reg  <= b_reg >> 4;
            carry  <= nib_cout;
            res_sh <= res_next;
            if (last) begin
                // Final nibble: publish the completed shift value directly.
                sum  <= res_next;
                cout <= nib_cout;
`ifdef NSA_OVERFLOW_EN
                ovf  <= (a_msb ~^ b_msb) & (a_msb ^ res_next[WIDTH-1]);
`endif
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (start) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            cnt   <= '0;
`ifdef NSA_OVERFLOW_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;
  localparam int WIDTH = 16;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [1:0]       dbg_state;
`ifdef NSA_OVERFLOW_EN
  logic             ovf;
`endif

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .dbg_state (dbg_state)
`ifdef NSA_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  int total = 0;
  int bad = 0;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ovf(input string tag, input logic exp);
`ifdef NSA_OVERFLOW_EN
    check(tag, {31'd0, ovf}, {31'd0, exp});
`endif
  endtask

  // One full transaction with start pulsed for a single cycle. Checks busy
  // for 4 cycles, sum/cout holding their previous values during RUN, the
  // one-cycle done pulse with the result, and the return to IDLE.
  task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                        input logic op_cin, input logic [WIDTH-1:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf,
                        input logic [WIDTH-1:0] prev_sum, input logic prev_cout);
    a = op_a; b = op_b; cin = op_cin; start = 1'b1;
    step();
    start = 1'b0;
    a = $urandom_range(0, 16'hFFFF);
    b = $urandom_range(0, 16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      check("run_busy", {31'd0, busy}, 32'd1);
      check("run_done", {31'd0, done}, 32'd0);
      check("run_sum_hold", {16'd0, sum}, {16'd0, prev_sum});
      check("run_cout_hold", {31'd0, cout}, {31'd0, prev_cout});
      if (i < 3) step();
    end
    step();
    check("done_pulse", {31'd0, done}, 32'd1);
    check("done_busy", {31'd0, busy}, 32'd0);
    check("done_state", {30'd0, dbg_state}, 32'd2);
    check("sum", {16'd0, sum}, {16'd0, exp_sum});
    check("cout", {31'd0, cout}, {31'd0, exp_cout});
    check_ovf("ovf", exp_ovf);
    step();
    check("after_done", {31'd0, done}, 32'd0);
    check("after_busy", {31'd0, busy}, 32'd0);
    check("after_sum_hold", {16'd0, sum}, {16'd0, exp_sum});
  endtask

  // ---------------- back-to-back vectors ----------------
  logic [WIDTH-1:0] bb_a   [4] = '{16'hA5A5, 16'h1357, 16'hF000, 16'h8000};
  logic [WIDTH-1:0] bb_b   [4] = '{16'h5A5A, 16'h2468, 16'h1000, 16'h8000};
  logic             bb_cin [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [WIDTH-1:0] bb_sum [4] = '{16'h0000, 16'h37BF, 16'h0001, 16'h0000};
  logic             bb_cout[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic             bb_ovf [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    step();
    step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    check_ovf("rst_ovf", 1'b0);
    rst = 1'b0;
    step();
    check("idle_state", {30'd0, dbg_state}, 32'd0);

    // Carry ripples through every nibble
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
    // Carry-in used; sum held at 0x0000 during RUN
    run_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 16'h0000, 1'b1);
    // Positive overflow into the sign bit
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 16'h5556, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0);

    // start during RUN is ignored
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    step();                                   // edge 0
    start = 1'b0;
    step();                                   // edge 1
    a = 16'h0F0F; b = 16'h0101; start = 1'b1; // pulse on 2nd RUN cycle
    step();                                   // edge 2
    start = 1'b0;
    check("ign_busy", {31'd0, busy}, 32'd1);
    step();                                   // edge 3
    check("ign_done_early", {31'd0, done}, 32'd0);
    step();                                   // edge 4
    check("ign_done", {31'd0, done}, 32'd1);
    check("ign_sum", {16'd0, sum}, 32'h3333);
    check("ign_cout", {31'd0, cout}, 32'd0);
    check_ovf("ign_ovf", 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("ign_single_done", {31'd0, done}, 32'd0);
      check("ign_idle_busy", {31'd0, busy}, 32'd0);
    end

    // Reset mid-RUN after two nibbles
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    step();                                   // edge 0
    start = 1'b0;
    step();                                   // edge 1
    step();                                   // edge 2
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_sum", {16'd0, sum}, 32'd0);
    check("mid_rst_cout", {31'd0, cout}, 32'd0);
    check_ovf("mid_rst_ovf", 1'b0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_no_done", {31'd0, done}, 32'd0);
      check("post_rst_no_busy", {31'd0, busy}, 32'd0);
    end
    run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 16'h0000, 1'b0);

    // start held high, alternating operands: a result every 5 cycles
    a = bb_a[0]; b = bb_b[0]; cin = bb_cin[0]; start = 1'b1;
    step();                                   // first accepting edge
    for (int k = 0; k < 4; k++) begin
      a = bb_a[(k + 1) % 4]; b = bb_b[(k + 1) % 4]; cin = bb_cin[(k + 1) % 4];
      for (int j = 0; j < 4; j++) begin
        check("bb_busy", {31'd0, busy}, 32'd1);
        check("bb_no_done", {31'd0, done}, 32'd0);
        step();
      end
      check("bb_done", {31'd0, done}, 32'd1);
      check("bb_done_busy", {31'd0, busy}, 32'd0);
      check("bb_sum", {16'd0, sum}, {16'd0, bb_sum[k]});
      check("bb_cout", {31'd0, cout}, {31'd0, bb_cout[k]});
      check_ovf("bb_ovf", bb_ovf[k]);
      if (k < 3) step();                      // DONE + start -> RUN
    end
    start = 1'b0;
    step();
    check("bb_end_done", {31'd0, done}, 32'd0);
    check("bb_end_busy", {31'd0, busy}, 32'd0);
    check("bb_end_state", {30'd0, dbg_state}, 32'd0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder that streams operands through a single 4-bit carry-lookahead nibble adder (`lookahead_adder_4bits`), one nibble per clock, least-significant nibble first. It feeds the nibble adder its operand slices and carry, and consumes its sum/cout each cycle into a result shift register. Used where area matters more than latency: one CLA slice instead of WIDTH/4 chained slices. Start/busy/done handshake toward the controlling datapath.

## Interface
- WIDTH, 16: operand width; multiple of 4, at least 4. NIB = WIDTH/4.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled on rising clk edge.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- cin  in  1  carry-in; sampled with start.
- busy  out  1  high while nibbles are being processed.
- done  out  1  single-cycle pulse: result valid.
- sum  out  WIDTH  registered result.
- cout  out  1  registered carry-out of MSB nibble.
- ovf  out  1  signed overflow (present only with NSA_OVERFLOW_EN).

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE/DONE + start=1: latch a, b, cin into operand/carry registers, clear nibble counter, go RUN. Otherwise DONE -> IDLE, IDLE stays.
- RUN: nibble adder gets low nibble of operand regs and carry reg. At each edge: nibble sum shifted into result shift register from the top, operand regs shift right by 4, carry reg <= nibble cout, counter++.
- After NIB RUN edges: load sum <= result shift register, cout <= carry reg, go DONE.
- start while RUN: ignored; operands not re-sampled.
- sum/cout hold their last value through IDLE and RUN; change only on RUN->DONE transition.
- Arithmetic: {cout, sum} = a + b + cin, exact, mod 2^(WIDTH+1).
- Counter width: clog2(NIB), minimum 1 bit; no wrap beyond NIB-1.

## Timing
- Reset (async, any state): state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, operand/carry/counter regs=0. Operation in flight is aborted; no done pulse.
- Edge 0: start sampled high (in IDLE or DONE). busy=1 from edge 0 until edge NIB.
- Edges 1..NIB: nibble 0..NIB-1 processed.
- After edge NIB: state DONE, done=1, busy=0, sum/cout valid.
- After edge NIB+1: done=0 unless a new start was sampled at edge NIB+1 (back-to-back: busy=1 again, no idle bubble).
- Latency start-edge to done-high: NIB edges (WIDTH=16: done high in the cycle after the 4th edge following start).
- Throughput: one result per NIB+1 cycles back-to-back.
- done and busy are never high together.

## Configuration
- NSA_OVERFLOW_EN defined: ovf port present; on RUN->DONE, ovf <= a[WIDTH-1] ~^ b[WIDTH-1] & (a[WIDTH-1] ^ sum[WIDTH-1]) using latched operand MSBs (captured at start); held with sum; reset 0.
- NSA_OVERFLOW_EN undefined: ovf port and its MSB capture registers absent; all other behaviour identical.

## Test plan
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0, start 1 cycle -> busy 4 cycles, done pulse 1 cycle, sum=0x0000, cout=1.
- a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; sum holds prior value (0x0000) throughout RUN.
- With NSA_OVERFLOW_EN: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; then a=0xFFFF, b=0x0001 -> ovf=0, cout=1.
- start pulsed again on 2nd RUN cycle with a=0x0F0F, b=0x0101 -> ignored; result still from first operands, single done pulse.
- rst asserted mid-RUN (after 2 nibbles) -> busy/done/sum/cout immediately 0, no done pulse; next start completes normally.
- start held high continuously, alternating operands -> done every 5th cycle, each sum correct, busy never overlaps done.
